// File: rtl/instr_decode_stage.sv
// RV32I decode stage: register file, immediate generation, control decode, decode->exec pipeline register.
// Latency: one cycle from instr_decode to the *_exec outputs; register file reads are combinational.
// Backpressure: stall_decode holds the pipeline register; flush_exec loads a bubble and overrides stall.
// Optional build macro FORWARD_WB_EN: write-through of the writeback port into same-cycle reads.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_decode,
  input  logic [XLEN-1:0] pc_decode,
  input  logic [XLEN-1:0] next_pc_decode,
  input  logic            stall_decode,
  input  logic            flush_exec,
  input  logic            reg_write_wb,
  input  logic [4:0]      rd_wb,
  input  logic [XLEN-1:0] result_wb,
  output logic [XLEN-1:0] rd1_exec,
  output logic [XLEN-1:0] rd2_exec,
  output logic [XLEN-1:0] imm_exec,
  output logic [XLEN-1:0] pc_exec,
  output logic [XLEN-1:0] next_pc_exec,
  output logic [4:0]      rs1_exec,
  output logic [4:0]      rs2_exec,
  output logic [4:0]      rd_exec,
  output logic [2:0]      funct3_exec,
  output logic [3:0]      alu_ctrl_exec,
  output logic            alu_src_a_exec,
  output logic            alu_src_b_exec,
  output logic [1:0]      result_src_exec,
  output logic            reg_write_exec,
  output logic            mem_write_exec,
  output logic            branch_exec,
  output logic            jump_exec,
  output logic            jalr_exec,
  output logic            illegal_exec
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_NPC  = 2'b10;

  // Everything the exec stage consumes, carried as one pipeline word so
  // reset, flush and stall act on it uniformly.
  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } dx_t;

  // x0 has no storage; reads of index 0 fall through to the zero default.
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  dx_t             r_dx;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7_b5;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  logic [4:0]      w_rs1_idx;
  logic [4:0]      w_rs2_idx;
  logic [4:0]      w_rd_idx;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu_ctrl;
  logic            w_alu_src_a;
  logic            w_alu_src_b;
  logic [1:0]      w_result_src;
  logic            w_reg_write;
  logic            w_mem_write;
  logic            w_branch;
  logic            w_jump;
  logic            w_jalr;
  logic            w_illegal;
  dx_t             w_dx;

  assign w_opcode    = instr_decode[6:0];
  assign w_funct3    = instr_decode[14:12];
  assign w_funct7_b5 = instr_decode[30];

  assign w_imm_i = {{20{instr_decode[31]}}, instr_decode[31:20]};
  assign w_imm_s = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
  assign w_imm_b = {{19{instr_decode[31]}}, instr_decode[31], instr_decode[7],
                    instr_decode[30:25], instr_decode[11:8], 1'b0};
  assign w_imm_u = {instr_decode[31:12], 12'b0};
  assign w_imm_j = {{11{instr_decode[31]}}, instr_decode[31], instr_decode[19:12],
                    instr_decode[20], instr_decode[30:21], 1'b0};

  // ALU op from funct3; the funct7[5] alternate means sub only for R-type,
  // but selects sra for shifts in both R and I forms.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

  // Register file write port; x1..x31 cleared on reset, x0 writes dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (reg_write_wb && (rd_wb != 5'd0)) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_wb == 5'(i)) r_regs[i] <= result_wb;
      end
    end
  end

  // Register indices per format: rs2 only where the format has one, rd
  // suppressed for store/branch, rs1 forced to x0 for lui.
  always_comb begin
    w_rs1_idx = instr_decode[19:15];
    w_rs2_idx = 5'd0;
    w_rd_idx  = instr_decode[11:7];
    case (w_opcode)
      OP_R: w_rs2_idx = instr_decode[24:20];
      OP_STORE, OP_BRANCH: begin
        w_rs2_idx = instr_decode[24:20];
        w_rd_idx  = 5'd0;
      end
      OP_LUI:  w_rs1_idx = 5'd0;
      default: ;
    endcase
  end

  // Combinational register file reads, optionally bypassing the write port.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (w_rs1_idx == 5'(i)) w_rd1 = r_regs[i];
      if (w_rs2_idx == 5'(i)) w_rd2 = r_regs[i];
    end
`ifdef FORWARD_WB_EN
    if (reg_write_wb && (rd_wb != 5'd0)) begin
      if (w_rs1_idx == rd_wb) w_rd1 = result_wb;
      if (w_rs2_idx == rd_wb) w_rd2 = result_wb;
    end
`endif
  end

  // Main control decode by opcode; anything unrecognised is flagged illegal.
  always_comb begin
    w_imm        = '0;
    w_alu_ctrl   = ALU_ADD;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 1'b0;
    w_result_src = RES_ALU;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jalr       = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_alu_ctrl  = alu_sel(w_funct3, w_funct7_b5, 1'b1);
        w_reg_write = 1'b1;
      end
      OP_IALU: begin
        w_alu_ctrl  = alu_sel(w_funct3, w_funct7_b5, 1'b0);
        w_alu_src_b = 1'b1;
        w_imm       = w_imm_i;
        w_reg_write = 1'b1;
      end
      OP_LOAD: begin
        w_alu_src_b  = 1'b1;
        w_imm        = w_imm_i;
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
      end
      OP_STORE: begin
        w_alu_src_b = 1'b1;
        w_imm       = w_imm_s;
        w_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        w_alu_ctrl = ALU_SUB;
        w_imm      = w_imm_b;
        w_branch   = 1'b1;
      end
      OP_JAL: begin
        w_imm        = w_imm_j;
        w_jump       = 1'b1;
        w_result_src = RES_NPC;
        w_reg_write  = 1'b1;
      end
      OP_JALR: begin
        w_imm        = w_imm_i;
        w_jump       = 1'b1;
        w_jalr       = 1'b1;
        w_result_src = RES_NPC;
        w_reg_write  = 1'b1;
      end
      OP_LUI: begin
        w_imm       = w_imm_u;
        w_alu_src_b = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_imm       = w_imm_u;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 1'b1;
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Assemble the next pipeline word; an illegal instruction travels as a
  // bubble that keeps only its PCs and the illegal flag for the trap logic.
  always_comb begin
    w_dx         = '0;
    w_dx.pc      = pc_decode;
    w_dx.next_pc = next_pc_decode;
    w_dx.illegal = w_illegal;
    if (!w_illegal) begin
      w_dx.rd1        = w_rd1;
      w_dx.rd2        = w_rd2;
      w_dx.imm        = w_imm;
      w_dx.rs1        = w_rs1_idx;
      w_dx.rs2        = w_rs2_idx;
      w_dx.rd         = w_rd_idx;
      w_dx.funct3     = w_funct3;
      w_dx.alu_ctrl   = w_alu_ctrl;
      w_dx.alu_src_a  = w_alu_src_a;
      w_dx.alu_src_b  = w_alu_src_b;
      w_dx.result_src = w_result_src;
      w_dx.reg_write  = w_reg_write;
      w_dx.mem_write  = w_mem_write;
      w_dx.branch     = w_branch;
      w_dx.jump       = w_jump;
      w_dx.jalr       = w_jalr;
    end
  end

  // Decode->exec register: flush wins over stall, stall holds, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dx <= '0;
    end else if (flush_exec) begin
      r_dx <= '0;
    end else if (!stall_decode) begin
      r_dx <= w_dx;
    end
  end

  assign rd1_exec        = r_dx.rd1;
  assign rd2_exec        = r_dx.rd2;
  assign imm_exec        = r_dx.imm;
  assign pc_exec         = r_dx.pc;
  assign next_pc_exec    = r_dx.next_pc;
  assign rs1_exec        = r_dx.rs1;
  assign rs2_exec        = r_dx.rs2;
  assign rd_exec         = r_dx.rd;
  assign funct3_exec     = r_dx.funct3;
  assign alu_ctrl_exec   = r_dx.alu_ctrl;
  assign alu_src_a_exec  = r_dx.alu_src_a;
  assign alu_src_b_exec  = r_dx.alu_src_b;
  assign result_src_exec = r_dx.result_src;
  assign reg_write_exec  = r_dx.reg_write;
  assign mem_write_exec  = r_dx.mem_write;
  assign branch_exec     = r_dx.branch;
  assign jump_exec       = r_dx.jump;
  assign jalr_exec       = r_dx.jalr;
  assign illegal_exec    = r_dx.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: drives instructions and writeback traffic,
// queues hand-derived expected exec words, and compares them one cycle later.
// Build with FORWARD_WB_EN defined to check the write-through variant.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_decode, pc_decode, next_pc_decode;
  logic        stall_decode, flush_exec, reg_write_wb;
  logic [4:0]  rd_wb;
  logic [31:0] result_wb;
  logic [31:0] rd1_exec, rd2_exec, imm_exec, pc_exec, next_pc_exec;
  logic [4:0]  rs1_exec, rs2_exec, rd_exec;
  logic [2:0]  funct3_exec;
  logic [3:0]  alu_ctrl_exec;
  logic        alu_src_a_exec, alu_src_b_exec;
  logic [1:0]  result_src_exec;
  logic        reg_write_exec, mem_write_exec, branch_exec, jump_exec, jalr_exec, illegal_exec;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, npc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        sa, sb;
    logic [1:0]  rs;
    logic        rw, mw, br, j, jr, ill;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [31:0] OLD_X5 = 32'hDEADBEEF;
  localparam logic [31:0] NEW_X5 = 32'hCAFEF00D;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_decode(instr_decode), .pc_decode(pc_decode), .next_pc_decode(next_pc_decode),
    .stall_decode(stall_decode), .flush_exec(flush_exec),
    .reg_write_wb(reg_write_wb), .rd_wb(rd_wb), .result_wb(result_wb),
    .rd1_exec(rd1_exec), .rd2_exec(rd2_exec), .imm_exec(imm_exec),
    .pc_exec(pc_exec), .next_pc_exec(next_pc_exec),
    .rs1_exec(rs1_exec), .rs2_exec(rs2_exec), .rd_exec(rd_exec),
    .funct3_exec(funct3_exec), .alu_ctrl_exec(alu_ctrl_exec),
    .alu_src_a_exec(alu_src_a_exec), .alu_src_b_exec(alu_src_b_exec),
    .result_src_exec(result_src_exec), .reg_write_exec(reg_write_exec),
    .mem_write_exec(mem_write_exec), .branch_exec(branch_exec),
    .jump_exec(jump_exec), .jalr_exec(jalr_exec), .illegal_exec(illegal_exec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Pop the oldest expectation and compare it against every exec output.
  task automatic compare_out();
    exp_t  x;
    string n;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    n = name_q.pop_front();
    chk({n, ".rd1"}, rd1_exec, x.rd1);
    chk({n, ".rd2"}, rd2_exec, x.rd2);
    chk({n, ".imm"}, imm_exec, x.imm);
    chk({n, ".pc"}, pc_exec, x.pc);
    chk({n, ".next_pc"}, next_pc_exec, x.npc);
    chk({n, ".rs1"}, 32'(rs1_exec), 32'(x.rs1));
    chk({n, ".rs2"}, 32'(rs2_exec), 32'(x.rs2));
    chk({n, ".rd"}, 32'(rd_exec), 32'(x.rd));
    chk({n, ".funct3"}, 32'(funct3_exec), 32'(x.f3));
    chk({n, ".alu_ctrl"}, 32'(alu_ctrl_exec), 32'(x.alu));
    chk({n, ".alu_src_a"}, 32'(alu_src_a_exec), 32'(x.sa));
    chk({n, ".alu_src_b"}, 32'(alu_src_b_exec), 32'(x.sb));
    chk({n, ".result_src"}, 32'(result_src_exec), 32'(x.rs));
    chk({n, ".reg_write"}, 32'(reg_write_exec), 32'(x.rw));
    chk({n, ".mem_write"}, 32'(mem_write_exec), 32'(x.mw));
    chk({n, ".branch"}, 32'(branch_exec), 32'(x.br));
    chk({n, ".jump"}, 32'(jump_exec), 32'(x.j));
    chk({n, ".jalr"}, 32'(jalr_exec), 32'(x.jr));
    chk({n, ".illegal"}, 32'(illegal_exec), 32'(x.ill));
  endtask

  // One decode cycle: drive on the falling edge, push the expectation held
  // in e, then compare just after the capturing rising edge.
  task automatic drive(input string n, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    @(negedge clk);
    instr_decode   = ins;
    pc_decode      = pc;
    next_pc_decode = pc + 32'd4;
    stall_decode   = st;
    flush_exec     = fl;
    reg_write_wb   = we;
    rd_wb          = wrd;
    result_wb      = wd;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    reg_write_wb = 1'b0;
    compare_out();
  endtask

  task automatic base(input logic [31:0] pc);
    e     = '0;
    e.pc  = pc;
    e.npc = pc + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_decode = '0; pc_decode = '0; next_pc_decode = '0;
    stall_decode = 1'b0; flush_exec = 1'b0;
    reg_write_wb = 1'b0; rd_wb = '0; result_wb = '0;

    #3;
    e = '0;
    exp_q.push_back(e); name_q.push_back("reset");
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Preload registers through the writeback port while flushing.
    e = '0;
    drive("wb_x5", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, OLD_X5);
    drive("wb_x6", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h1);
    drive("wb_x26", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd26, 32'h55);

    // add x7,x5,x6
    base(32'h100); e.rd1 = OLD_X5; e.rd2 = 32'h1; e.rs1 = 5; e.rs2 = 6; e.rd = 7; e.rw = 1;
    drive("add", 32'h006283B3, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // sub x8,x5,x6
    base(32'h104); e.rd1 = OLD_X5; e.rd2 = 32'h1; e.rs1 = 5; e.rs2 = 6; e.rd = 8; e.rw = 1;
    e.alu = 4'd1;
    drive("sub", 32'h40628433, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // add x7,x5,x6 while x5 is being rewritten in the same cycle
    base(32'h108); e.rd2 = 32'h1; e.rs1 = 5; e.rs2 = 6; e.rd = 7; e.rw = 1;
`ifdef FORWARD_WB_EN
    e.rd1 = NEW_X5;
`else
    e.rd1 = OLD_X5;
`endif
    drive("same_cycle_wb", 32'h006283B3, 32'h108, 1'b0, 1'b0, 1'b1, 5'd5, NEW_X5);

    base(32'h10C); e.rd1 = NEW_X5; e.rd2 = 32'h1; e.rs1 = 5; e.rs2 = 6; e.rd = 7; e.rw = 1;
    drive("after_wb", 32'h006283B3, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // beq x0,x0,-8
    base(32'h110); e.imm = 32'hFFFFFFF8; e.br = 1; e.alu = 4'd1;
    drive("beq", 32'hFE000CE3, 32'h110, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // jal x1,+2048
    base(32'h114); e.imm = 32'h800; e.j = 1; e.rs = 2'b10; e.rw = 1; e.rd = 1;
    drive("jal", 32'h001000EF, 32'h114, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // addi x9,x6,-1
    base(32'h118); e.rd1 = 32'h1; e.imm = 32'hFFFFFFFF; e.sb = 1; e.rw = 1; e.rs1 = 6; e.rd = 9;
    drive("addi", 32'hFFF30493, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // addi x11,x0,0x400: bit 30 set must not turn add into sub
    base(32'h11C); e.imm = 32'h400; e.sb = 1; e.rw = 1; e.rd = 11;
    drive("addi_bit30", 32'h40000593, 32'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // srai x10,x5,4
    base(32'h120); e.rd1 = NEW_X5; e.imm = 32'h404; e.alu = 4'd9; e.sb = 1; e.rw = 1;
    e.rs1 = 5; e.rd = 10; e.f3 = 3'd5;
    drive("srai", 32'h4042D513, 32'h120, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // lw x12,8(x6)
    base(32'h124); e.rd1 = 32'h1; e.imm = 32'h8; e.f3 = 3'd2; e.sb = 1; e.rs = 2'b01; e.rw = 1;
    e.rs1 = 6; e.rd = 12;
    drive("lw", 32'h00832603, 32'h124, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // sw x5,-4(x6)
    base(32'h128); e.rd1 = 32'h1; e.rd2 = NEW_X5; e.imm = 32'hFFFFFFFC; e.f3 = 3'd2; e.sb = 1;
    e.mw = 1; e.rs1 = 6; e.rs2 = 5;
    drive("sw", 32'hFE532E23, 32'h128, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // lui x13,0xABCD0: raw rs1 field is x26 (nonzero) but must read as x0
    base(32'h12C); e.imm = 32'hABCD0000; e.sb = 1; e.rw = 1; e.rd = 13;
    drive("lui", 32'hABCD06B7, 32'h12C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // auipc x14,0x80000
    base(32'h130); e.imm = 32'h80000000; e.sa = 1; e.sb = 1; e.rw = 1; e.rd = 14;
    drive("auipc", 32'h80000717, 32'h130, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // jalr x1,12(x5)
    base(32'h134); e.rd1 = NEW_X5; e.imm = 32'hC; e.j = 1; e.jr = 1; e.rs = 2'b10; e.rw = 1;
    e.rd = 1; e.rs1 = 5;
    drive("jalr", 32'h00C280E7, 32'h134, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Stall holds the add for two cycles while a beq sits at the input.
    base(32'h200); e.rd1 = NEW_X5; e.rd2 = 32'h1; e.rs1 = 5; e.rs2 = 6; e.rd = 7; e.rw = 1;
    drive("stall_load", 32'h006283B3, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive("stall_hold1", 32'hFE000CE3, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    drive("stall_hold2", 32'hFE000CE3, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    e = '0;
    drive("stall_flush", 32'hFE000CE3, 32'h204, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);

    // Writes to x0 are dropped, including one in the same cycle as the read.
    e = '0;
    drive("x0_write", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1234);
    base(32'h300); e.rd = 15; e.rw = 1;
    drive("x0_read", 32'h000007B3, 32'h300, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);

    // Unknown opcode 1111111
    base(32'h304); e.ill = 1;
    drive("illegal", 32'h0000007F, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    exp_q.push_back(e); name_q.push_back("async_reset");
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Register file was cleared by reset: x5 and x6 now read 0.
    base(32'h400); e.rs1 = 5; e.rs2 = 6; e.rd = 7; e.rw = 1;
    drive("post_reset_add", 32'h006283B3, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
